instr_fetch_sequencer: RTL and testbench
========================================

INSTR_FETCH_SEQUENCER -- requirements
Module: instr_fetch_sequencer

Interface
REQ-001 The block SHALL have port i_clk, input, 1 bit: clock; all state updates on the rising edge.
REQ-002 The block SHALL have port i_reset, input, 1 bit: reset, synchronous, active-low.
REQ-003 The block SHALL have port i_mem_valid, input, 1 bit: memory word available.
REQ-004 The block SHALL have port i_mem_data, input, 32 bits: 4 instruction bytes, byte at lowest address in [7:0].
REQ-005 The block SHALL have port o_mem_ready, output, 1 bit: the block can accept a memory word this cycle.
REQ-006 The block SHALL have port o_fetch_addr, output, 32 bits: word-aligned address of the next word to fetch.
REQ-007 The block SHALL have port o_dec_valid, output, 1 bit: the decode window holds 4 valid bytes.
REQ-008 The block SHALL have port o_dec_data, output, 32 bits: decode window, oldest byte in [7:0].
REQ-009 The block SHALL have port o_pc, output, 32 bits: byte address of o_dec_data[7:0].
REQ-010 The block SHALL have port i_dec_ack, input, 1 bit: the decoder consumed an instruction.
REQ-011 The block SHALL have port i_dec_size, input, 3 bits: bytes consumed, legal range 1..4.
REQ-012 The block SHALL have port o_size_err, output, 1 bit: one-cycle pulse on an illegal size.
REQ-013 The block SHALL have port i_flush, input, 1 bit: redirect request.
REQ-014 The block SHALL have port i_flush_addr, input, 32 bits: redirect target byte address.

Function
REQ-015 The block SHALL hold an 8-byte FIFO byte queue with a count of 0..8.
REQ-016 The block SHALL drive o_dec_data from queue bytes 0..3; bytes beyond count are don't-care.
REQ-017 The block SHALL drive o_mem_ready = (count <= 4) combinationally.
REQ-018 Push: when i_mem_valid && o_mem_ready && !i_flush, the block SHALL append the word's bytes after any same-cycle pop and add 4 to o_fetch_addr.
REQ-019 Pop: when i_dec_ack && o_dec_valid && !i_flush && 1 <= i_dec_size <= 4, the block SHALL shift the queue down by i_dec_size bytes and add i_dec_size to o_pc.
REQ-020 On a simultaneous push and pop, the next count SHALL be count - size + pushed bytes, with no byte lost or duplicated.
REQ-021 i_dec_ack with i_dec_size of 0 or greater than 4 while o_dec_valid is high SHALL perform no pop and SHALL pulse o_size_err high for the next cycle.
REQ-022 i_dec_ack while o_dec_valid is low SHALL be ignored, with no error.
REQ-023 The block SHALL implement state machine states S_FILL, S_RUN and S_ALIGN.
REQ-024 In S_FILL, o_dec_valid SHALL be 0, and the state SHALL go to S_RUN when the next count is 4 or more.
REQ-025 In S_RUN, o_dec_valid SHALL be 1, and the state SHALL go to S_FILL when the next count is below 4.
REQ-026 In S_ALIGN, o_dec_valid SHALL be 0; the first accepted word SHALL push only bytes [skip..3] (4 - skip bytes), then the state SHALL go to S_FILL, or to S_RUN if the count reaches 4 or more.
REQ-027 i_flush SHALL have priority over push and pop in the same cycle (both discarded).
REQ-028 On i_flush, the next cycle SHALL have count = 0, state = S_ALIGN, skip = i_flush_addr[1:0], o_fetch_addr = {i_flush_addr[31:2], 2'b00} and o_pc = i_flush_addr.
REQ-029 A flush while already in S_ALIGN SHALL restart alignment with the new address.
REQ-030 o_pc and o_fetch_addr SHALL wrap modulo 2^32.

Reset
REQ-031 When i_reset = 0 at a clock edge, the block SHALL set count = 0, state = S_FILL, skip = 0, o_fetch_addr = 0, o_pc = 0 and o_size_err = 0, taking effect immediately.
REQ-032 Reset SHALL override flush, push and pop in the same cycle, and SHALL discard any in-progress alignment or partially filled queue.

Verification
REQ-033 Reset then words 0x03020100 and 0x07060504 with no ack -> o_dec_valid = 1 after the first push, o_dec_data = 0x03020100, o_pc = 0, count = 8, o_mem_ready = 0, o_fetch_addr = 8.
REQ-034 From REQ-033, ack size 3 -> o_dec_data = 0x06050403, o_pc = 3, count = 5; then ack size 2 -> count = 3, o_dec_valid = 0, o_mem_ready = 1.
REQ-035 Count = 4 with ack size 4 and push 0x0B0A0908 in the same cycle -> count = 4, o_dec_data = 0x0B0A0908, o_dec_valid stays 1.
REQ-036 Flush to 0x00001006, then push 0xDDCCBBAA -> o_fetch_addr = 0x1004 after the flush and 0x1008 after the push; count = 2 with queue bytes 0xCC, 0xDD; o_pc = 0x1006; o_dec_valid = 0 until the next push.
REQ-037 Ack size 5 while valid -> no pop, o_size_err high for exactly one cycle; ack while invalid -> no error.
REQ-038 Flush and ack and push in the same cycle, then reset asserted mid-S_ALIGN -> flush wins with nothing consumed; reset returns every output to its REQ-031 value.

Source files
------------

// File: rtl/instr_fetch_sequencer.sv
// Instruction fetch sequencer: 8-byte queue between word-wide memory
// and a variable-length decoder, with redirect alignment.
module instr_fetch_sequencer (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_mem_valid,
  input  logic [31:0] i_mem_data,
  output logic        o_mem_ready,
  output logic [31:0] o_fetch_addr,
  output logic        o_dec_valid,
  output logic [31:0] o_dec_data,
  output logic [31:0] o_pc,
  input  logic        i_dec_ack,
  input  logic [2:0]  i_dec_size,
  output logic        o_size_err,
  input  logic        i_flush,
  input  logic [31:0] i_flush_addr
);

  typedef enum logic [1:0] {
    S_FILL  = 2'd0,
    S_RUN   = 2'd1,
    S_ALIGN = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [63:0] q, q_nxt;
  logic [3:0]  count, count_nxt;
  logic [1:0]  skip, skip_nxt;
  logic [31:0] faddr, faddr_nxt;
  logic [31:0] pc, pc_nxt;
  logic        err, err_nxt;

  logic        size_ok;
  logic        do_pop;
  logic        do_push;
  logic        bad_size;
  logic [3:0]  pop_n;
  logic [3:0]  push_n;
  logic [3:0]  cnt_mid;
  logic [31:0] word;
  logic [63:0] q_shift;
  logic [63:0] keep;

  assign o_mem_ready  = (count <= 4'd4);
  assign o_dec_valid  = (state == S_RUN);
  assign o_dec_data   = q[31:0];
  assign o_pc         = pc;
  assign o_fetch_addr = faddr;
  assign o_size_err   = err;

  always_comb begin
    size_ok  = (i_dec_size != 3'd0) && (i_dec_size <= 3'd4);
    do_pop   = i_dec_ack && o_dec_valid && !i_flush && size_ok;
    bad_size = i_dec_ack && o_dec_valid && !i_flush && !size_ok;
    do_push  = i_mem_valid && o_mem_ready && !i_flush;
    pop_n    = do_pop ? {1'b0, i_dec_size} : 4'd0;
    push_n   = 4'd0;
    if (do_push)
      push_n = (state == S_ALIGN) ? 4'd4 - {2'b00, skip} : 4'd4;
    cnt_mid  = count - pop_n;
  end

  // Head-of-word bytes below the redirect target are dropped in S_ALIGN.
  always_comb begin
    word = i_mem_data;
    if (state == S_ALIGN)
      word = i_mem_data >> {skip, 3'b000};
  end

  // Pop first, then append the new bytes right after the survivors.
  always_comb begin
    q_shift = q >> {pop_n, 3'b000};
    keep    = ~(64'hFFFF_FFFF_FFFF_FFFF << {cnt_mid, 3'b000});
    q_nxt   = q_shift;
    if (do_push)
      q_nxt = (q_shift & keep) | ({32'h0, word} << {cnt_mid, 3'b000});
  end

  always_comb begin
    count_nxt = cnt_mid + push_n;
    skip_nxt  = skip;
    faddr_nxt = faddr;
    pc_nxt    = pc;
    err_nxt   = bad_size;
    state_nxt = state;
    if (i_flush) begin
      count_nxt = 4'd0;
      skip_nxt  = i_flush_addr[1:0];
      faddr_nxt = {i_flush_addr[31:2], 2'b00};
      pc_nxt    = i_flush_addr;
      state_nxt = S_ALIGN;
    end else begin
      if (do_push)
        faddr_nxt = faddr + 32'd4;
      if (do_pop)
        pc_nxt = pc + {29'd0, i_dec_size};
      unique case (state)
        S_FILL: begin
          if (count_nxt >= 4'd4)
            state_nxt = S_RUN;
        end
        S_RUN: begin
          if (count_nxt < 4'd4)
            state_nxt = S_FILL;
        end
        S_ALIGN: begin
          if (do_push) begin
            skip_nxt  = 2'd0;
            state_nxt = (count_nxt >= 4'd4) ? S_RUN : S_FILL;
          end
        end
        default: state_nxt = S_FILL;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state <= S_FILL;
      q     <= 64'h0;
      count <= 4'd0;
      skip  <= 2'd0;
      faddr <= 32'h0;
      pc    <= 32'h0;
      err   <= 1'b0;
    end else begin
      state <= state_nxt;
      q     <= q_nxt;
      count <= count_nxt;
      skip  <= skip_nxt;
      faddr <= faddr_nxt;
      pc    <= pc_nxt;
      err   <= err_nxt;
    end
  end

endmodule

// File: tb/tb_instr_fetch_sequencer.sv
// Directed scoreboard bench for instr_fetch_sequencer.
module tb_instr_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_valid;
  logic [31:0] mem_data;
  logic        mem_ready;
  logic [31:0] fetch_addr;
  logic        dec_valid;
  logic [31:0] dec_data;
  logic [31:0] pc;
  logic        dec_ack;
  logic [2:0]  dec_size;
  logic        size_err;
  logic        flush;
  logic [31:0] flush_addr;

  int checks = 0;
  int errors = 0;

  typedef enum int {F_VALID, F_DATA, F_PC, F_FADDR, F_READY, F_ERR} fld_t;

  typedef struct {
    string       tag;
    fld_t        fld;
    logic [31:0] mask;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];

  instr_fetch_sequencer dut (
    .i_clk        (clk),
    .i_reset      (rst_n),
    .i_mem_valid  (mem_valid),
    .i_mem_data   (mem_data),
    .o_mem_ready  (mem_ready),
    .o_fetch_addr (fetch_addr),
    .o_dec_valid  (dec_valid),
    .o_dec_data   (dec_data),
    .o_pc         (pc),
    .i_dec_ack    (dec_ack),
    .i_dec_size   (dec_size),
    .o_size_err   (size_err),
    .i_flush      (flush),
    .i_flush_addr (flush_addr)
  );

  always #5 clk = ~clk;

  task automatic expm(input string tag, input fld_t f,
                      input logic [31:0] m, input logic [31:0] v);
    exp_t e;
    e.tag = tag; e.fld = f; e.mask = m; e.val = v;
    sb.push_back(e);
  endtask

  task automatic expv(input string tag, input fld_t f,
                      input logic [31:0] v);
    expm(tag, f, 32'hFFFF_FFFF, v);
  endtask

  function automatic logic [31:0] obs_of(input fld_t f);
    case (f)
      F_VALID: return {31'd0, dec_valid};
      F_DATA:  return dec_data;
      F_PC:    return pc;
      F_FADDR: return fetch_addr;
      F_READY: return {31'd0, mem_ready};
      default: return {31'd0, size_err};
    endcase
  endfunction

  task automatic drain();
    exp_t e;
    logic [31:0] o;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      o = obs_of(e.fld) & e.mask;
      checks++;
      assert (o === e.val) else begin
        errors++;
        $error("FAIL %s observed %h expected %h", e.tag, o, e.val);
      end
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] d,
                       input logic a, input logic [2:0] s,
                       input logic f, input logic [31:0] fa);
    mem_valid = v; mem_data = d;
    dec_ack = a; dec_size = s;
    flush = f; flush_addr = fa;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    drain();
    drive(0, 32'h0, 0, 3'd0, 0, 32'h0);
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, 32'h0, 0, 3'd0, 0, 32'h0);
    #2;
    // reset state
    expv("rst_valid", F_VALID, 0);
    expv("rst_pc", F_PC, 0);
    expv("rst_faddr", F_FADDR, 0);
    expv("rst_err", F_ERR, 0);
    expv("rst_ready", F_READY, 1);
    cyc();
    rst_n = 1'b1;

    drive(1, 32'h0302_0100, 0, 3'd0, 0, 32'h0);
    expv("p1_valid", F_VALID, 1);
    expv("p1_data", F_DATA, 32'h0302_0100);
    expv("p1_faddr", F_FADDR, 32'h4);
    expv("p1_ready", F_READY, 1);
    cyc();

    drive(1, 32'h0706_0504, 0, 3'd0, 0, 32'h0);
    expv("p2_data", F_DATA, 32'h0302_0100);
    expv("p2_pc", F_PC, 0);
    expv("p2_ready", F_READY, 0);
    expv("p2_faddr", F_FADDR, 32'h8);
    cyc();

    // full queue refuses the word
    drive(1, 32'hDEAD_BEEF, 0, 3'd0, 0, 32'h0);
    expv("full_faddr", F_FADDR, 32'h8);
    expv("full_data", F_DATA, 32'h0302_0100);
    cyc();

    drive(0, 32'h0, 1, 3'd3, 0, 32'h0);
    expv("a3_data", F_DATA, 32'h0605_0403);
    expv("a3_pc", F_PC, 32'h3);
    expv("a3_ready", F_READY, 0);
    cyc();

    drive(0, 32'h0, 1, 3'd2, 0, 32'h0);
    expv("a2_valid", F_VALID, 0);
    expv("a2_ready", F_READY, 1);
    expv("a2_pc", F_PC, 32'h5);
    cyc();

    drive(1, 32'h0B0A_0908, 0, 3'd0, 0, 32'h0);
    expv("p3_data", F_DATA, 32'h0807_0605);
    expv("p3_valid", F_VALID, 1);
    expv("p3_faddr", F_FADDR, 32'hC);
    cyc();

    drive(0, 32'h0, 1, 3'd3, 0, 32'h0);
    expv("a3b_data", F_DATA, 32'h0B0A_0908);
    expv("a3b_pc", F_PC, 32'h8);
    expv("a3b_ready", F_READY, 1);
    cyc();

    // count 4: pop 4 and push together
    drive(1, 32'h0F0E_0D0C, 1, 3'd4, 0, 32'h0);
    expv("pp_data", F_DATA, 32'h0F0E_0D0C);
    expv("pp_valid", F_VALID, 1);
    expv("pp_pc", F_PC, 32'hC);
    expv("pp_faddr", F_FADDR, 32'h10);
    expv("pp_ready", F_READY, 1);
    cyc();

    drive(0, 32'h0, 1, 3'd5, 0, 32'h0);
    expv("bad5_err", F_ERR, 1);
    expv("bad5_pc", F_PC, 32'hC);
    expv("bad5_data", F_DATA, 32'h0F0E_0D0C);
    cyc();
    expv("bad5_pulse", F_ERR, 0);
    cyc();

    drive(0, 32'h0, 1, 3'd0, 0, 32'h0);
    expv("bad0_err", F_ERR, 1);
    expv("bad0_valid", F_VALID, 1);
    cyc();

    drive(0, 32'h0, 0, 3'd0, 1, 32'h0000_1006);
    expv("fl_valid", F_VALID, 0);
    expv("fl_faddr", F_FADDR, 32'h1004);
    expv("fl_pc", F_PC, 32'h1006);
    expv("fl_err", F_ERR, 0);
    cyc();

    drive(0, 32'h0, 1, 3'd5, 0, 32'h0);
    expv("inv_err", F_ERR, 0);
    expv("inv_pc", F_PC, 32'h1006);
    cyc();

    drive(1, 32'hDDCC_BBAA, 0, 3'd0, 0, 32'h0);
    expv("al_faddr", F_FADDR, 32'h1008);
    expv("al_valid", F_VALID, 0);
    expm("al_bytes", F_DATA, 32'h0000_FFFF, 32'h0000_DDCC);
    expv("al_pc", F_PC, 32'h1006);
    cyc();

    drive(1, 32'h4433_2211, 0, 3'd0, 0, 32'h0);
    expv("al2_data", F_DATA, 32'h2211_DDCC);
    expv("al2_valid", F_VALID, 1);
    expv("al2_ready", F_READY, 0);
    cyc();

    // flush beats ack and push
    drive(1, 32'h5555_5555, 1, 3'd2, 1, 32'h0000_2001);
    expv("fap_valid", F_VALID, 0);
    expv("fap_pc", F_PC, 32'h2001);
    expv("fap_faddr", F_FADDR, 32'h2000);
    expv("fap_ready", F_READY, 1);
    cyc();

    drive(0, 32'h0, 0, 3'd0, 1, 32'h0000_3003);
    expv("refl_pc", F_PC, 32'h3003);
    expv("refl_faddr", F_FADDR, 32'h3000);
    cyc();

    drive(1, 32'h8877_6655, 0, 3'd0, 0, 32'h0);
    expm("sk3_byte", F_DATA, 32'h0000_00FF, 32'h88);
    expv("sk3_valid", F_VALID, 0);
    expv("sk3_faddr", F_FADDR, 32'h3004);
    cyc();

    drive(0, 32'h0, 0, 3'd0, 1, 32'h0000_5002);
    expv("fl5_pc", F_PC, 32'h5002);
    cyc();

    // reset mid-alignment overrides everything
    rst_n = 1'b0;
    drive(1, 32'h9999_9999, 1, 3'd1, 1, 32'h0000_7777);
    expv("mr_valid", F_VALID, 0);
    expv("mr_pc", F_PC, 0);
    expv("mr_faddr", F_FADDR, 0);
    expv("mr_err", F_ERR, 0);
    expv("mr_ready", F_READY, 1);
    cyc();
    rst_n = 1'b1;

    drive(1, 32'h1312_1110, 0, 3'd0, 0, 32'h0);
    expv("pr_data", F_DATA, 32'h1312_1110);
    expv("pr_valid", F_VALID, 1);
    expv("pr_faddr", F_FADDR, 32'h4);
    cyc();

    // address wrap
    drive(0, 32'h0, 0, 3'd0, 1, 32'hFFFF_FFFE);
    expv("wr_faddr", F_FADDR, 32'hFFFF_FFFC);
    cyc();
    drive(1, 32'hAABB_CCDD, 0, 3'd0, 0, 32'h0);
    expv("wr_faddr2", F_FADDR, 32'h0);
    cyc();
    drive(1, 32'h1122_3344, 0, 3'd0, 0, 32'h0);
    expv("wr_data", F_DATA, 32'h3344_AABB);
    expv("wr_pc", F_PC, 32'hFFFF_FFFE);
    cyc();
    drive(0, 32'h0, 1, 3'd4, 0, 32'h0);
    expv("wr_pc2", F_PC, 32'h2);
    expv("wr_valid", F_VALID, 0);
    expm("wr_bytes", F_DATA, 32'h0000_FFFF, 32'h0000_1122);
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
